mul_seq_ctrl: RTL
=================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: a multiply request is presented.
REQ-004 SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-005 SHALL have ports req_a and req_b, input, 32 bits each: operands.
REQ-006 SHALL have port req_signed, input, 1 bit: 1 = signed multiply, 0 = unsigned.
REQ-007 SHALL have port rd_hilo, input, 1 bit: the pipeline is reading HI/LO this cycle.
REQ-008 SHALL have port stall, output, 1 bit: the HI/LO read must be held off.
REQ-009 SHALL have ports hi and lo, output, 32 bits each: upper and lower product words.
REQ-010 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have ports mul_a and mul_b, output, 32 bits each, plus mul_sign, output, 1 bit: these drive the 4-stage multiplier.
REQ-013 SHALL have ports mul_uresult and mul_sresult, input, 64 bits each: the multiplier's unsigned and signed results.

Function
REQ-014 SHALL implement states IDLE and WAIT, with a 2-bit cycle counter cnt.
REQ-015 SHALL drive req_ready = (state==IDLE) and busy = (state==WAIT).
REQ-016 SHALL define an acceptance edge E0 as any edge where req_valid && req_ready && !rst.
- At E0: capture req_a, req_b and req_signed into operand registers; go to WAIT; set cnt=0.
REQ-017 SHALL ignore req_valid while in WAIT; the operands are not captured and there is no side effect.
REQ-018 SHALL drive mul_a, mul_b and mul_sign from the operand registers only.
- The registers are held constant from E0 until completion, because the multiplier's sign-correction stage uses live operand MSBs.
REQ-019 SHALL increment cnt on each edge while in WAIT.
REQ-020 SHALL complete at edge E4 (the edge where state==WAIT and cnt==3).
- Load {hi,lo} = mul_sign ? mul_sresult : mul_uresult, as a full 64-bit result with no truncation.
- Return to IDLE.
- Assert done for exactly the one cycle following E4.
REQ-021 SHALL give a fixed latency of 4 edges from acceptance to HI/LO update, with no data-dependent early exit.
REQ-022 SHALL allow the next request to be accepted at E5 at the earliest, giving a maximum throughput of one operation per 5 cycles.
REQ-023 SHALL drive stall = rd_hilo && busy, except as modified by REQ-030.
REQ-024 SHALL hold hi and lo unchanged except at completion or reset.
REQ-025 SHALL take rst over every other event when rst is asserted together with req_valid or together with completion.

Reset
REQ-026 SHALL, on rst, set state=IDLE, cnt=0, hi=0, lo=0, done=0 and the operand registers to 0.
- Resulting outputs: req_ready=1, busy=0, stall=0, and mul_a=mul_b=0, mul_sign=0.
REQ-027 SHALL, on rst mid-operation, abandon the operation: no done pulse, no HI/LO write, and req_ready=1 in the cycle after reset is released.

Configuration
REQ-028 SHALL provide a forwarding option controlled by the macro MUL_SEQ_CTRL_HILO_FWD_EN.
REQ-029 SHALL, when the macro is undefined, drive hi and lo as pure register outputs, and keep stall asserted for rd_hilo throughout WAIT, including the cnt==3 cycle.
REQ-030 SHALL, when the macro is defined, handle the cnt==3 cycle as follows:
- hi and lo combinationally forward the selected multiplier result.
- stall is 0 even when rd_hilo=1.
- In all other cycles, behaviour is identical to REQ-029.

Verification
REQ-031 SHALL cover: unsigned request 0xFFFFFFFF x 0x00000002 accepted at E0 -> busy for 4 cycles, then at E4 hi=0x00000001, lo=0xFFFFFFFE, with done high for one cycle.
REQ-032 SHALL cover: signed request 0xFFFFFFFD (-3) x 0x00000005 -> at E4 hi=0xFFFFFFFF, lo=0xFFFFFFF1; the same operands unsigned -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-033 SHALL cover: a second req_valid with 7 x 9 at E2 of an operation -> ignored, mul_a/mul_b unchanged, and the result from the first operation only; the re-presented request is accepted at E5 -> hi=0, lo=0x3F at E9.
REQ-034 SHALL cover: rst pulsed at E2 of an operation -> no done pulse, hi=lo=0, req_ready=1 after release.
REQ-035 SHALL cover: rd_hilo held high across an operation of 6 x 7 -> stall high for cycles with cnt=0..3 when the macro is undefined, and high for cnt=0..2 with lo=0x2A forwarded in the cnt=3 cycle when the macro is defined.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for an external 4-stage multiplier: accepts one request, holds the
// operands steady for four edges, then latches the 64-bit product into HI/LO.
// Optional HI/LO forwarding in the final wait cycle: define MUL_SEQ_CTRL_HILO_FWD_EN.
module mul_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_signed,
   input  logic        rd_hilo,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_sign,
   input  logic [63:0] mul_uresult,
   input  logic [63:0] mul_sresult
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic        sign_q, sign_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;

   logic        accept, complete;
   logic [63:0] result;

   assign accept   = (state_q == IDLE) && req_valid;
   assign complete = (state_q == WAIT) && (cnt_q == 2'd3);
   assign result   = sign_q ? mul_sresult : mul_uresult;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         sign_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sign_q  <= sign_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // Fixed four-edge wait: no early exit, so latency never depends on operand values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = WAIT;
               cnt_d   = 2'd0;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // Operands only move on acceptance; the multiplier's sign stage reads them live.
   always_comb begin
      opa_d  = accept ? req_a      : opa_q;
      opb_d  = accept ? req_b      : opb_q;
      sign_d = accept ? req_signed : sign_q;
      hi_d   = complete ? result[63:32] : hi_q;
      lo_d   = complete ? result[31:0]  : lo_q;
      done_d = complete;
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      busy      = (state_q == WAIT);
      done      = done_q;
      mul_a     = opa_q;
      mul_b     = opb_q;
      mul_sign  = sign_q;
`ifdef MUL_SEQ_CTRL_HILO_FWD_EN
      hi    = complete ? result[63:32] : hi_q;
      lo    = complete ? result[31:0]  : lo_q;
      stall = rd_hilo && busy && !complete;
`else
      hi    = hi_q;
      lo    = lo_q;
      stall = rd_hilo && busy;
`endif
   end

endmodule
